// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, frame
// constants, the debug snapshot struct and a constant-width helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  // Snapshot of receiver internals for checkers and waveform browsing.
  // fifo_level is zero-extended from the FIFO count register.
  typedef struct packed {
    state_t     state;
    logic [2:0] bit_idx;
    logic [7:0] fifo_level;
  } rx_dbg_t;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. rdata always reflects the head entry while
// not empty and reads as zero when empty. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are don't-care until written, reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop line synchronizer, start/data/stop FSM with
// mid-bit sampling, and a show-ahead receive FIFO on a valid/ready stream.
//
// Stream handshake: rx_valid is high whenever the FIFO holds a byte and
// rx_data is that head byte. A byte is consumed on a rising clk edge where
// rx_valid && rx_ready are both high. While rx_valid && !rx_ready the head
// is held stable. rx_ready may be high with rx_valid low; nothing happens.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output rx_dbg_t              dbg
);

  localparam int CW   = clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

  logic rx_meta;
  logic rx_s;

  state_t               state_q;
  state_t               state_d;
  logic [CW-1:0]        bit_cnt;
  logic [CW-1:0]        cnt_d;
  logic [2:0]           bit_idx;
  logic [2:0]           idx_d;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_d;
  logic                 push;
  logic                 frame_err_d;
  logic                 overrun_d;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;
  logic [clog2(FIFO_DEPTH):0] fifo_count;

  assign pop      = rx_valid && rx_ready;
  assign rx_valid = !fifo_empty;
  assign busy     = (state_q != ST_IDLE);

  assign dbg.state      = state_q;
  assign dbg.bit_idx    = bit_idx;
  assign dbg.fifo_level = 8'(fifo_count);

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state, bit timing counter, bit index, shift register and pulse flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt   <= cnt_d;
      bit_idx   <= idx_d;
      shreg     <= shreg_d;
      frame_err <= frame_err_d;
      overrun   <= overrun_d;
    end
  end

  // Next-state logic: sample mid start bit, then once per bit period after it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = bit_cnt + 1'b1;
    idx_d       = bit_idx;
    shreg_d     = shreg;
    push        = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_cnt == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (bit_cnt == LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg[DATA_BITS-1:1]};
          if (bit_idx == LAST_IDX) begin
            state_d = ST_STOP;
          end else begin
            idx_d = bit_idx + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (bit_cnt == LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
            // A same-cycle pop frees a slot, so a full FIFO can still take the byte.
            if (fifo_full && !pop) begin
              overrun_d = 1'b1;
            end else begin
              push = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (shreg),
    .pop   (pop),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
